// File: rtl/seg_char_encoder.sv
// seg_char_encoder: turns active-low 7-segment patterns back into 2-bit codes and packs three of them into a 6-bit word.
// Defining SEG_ENC_STRICT_EN drops unrecognised patterns instead of storing them as blank.
module seg_char_encoder (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    input  logic       i_seg_valid,
    output logic       o_seg_ready,
    output logic [5:0] o_word,
    output logic       o_word_valid,
    input  logic       i_word_ready,
    output logic       o_err,
    output logic [1:0] o_count
);
    typedef enum logic {COLLECT, FULL} state_t;
    state_t     r_state, w_state_nx;
    logic [5:0] r_word, w_word_nx;
    logic       r_err, w_err_nx;
    logic [1:0] r_count, w_count_nx;
    logic [1:0] w_code;
    logic       w_known, w_accept, w_store;
    always_comb begin
        w_code  = (i_seg == 7'b0100001) ? 2'b00 :
                  (i_seg == 7'b0000110) ? 2'b01 :
                  (i_seg == 7'b1111001) ? 2'b10 : 2'b11;
        w_known = (i_seg == 7'b0100001) || (i_seg == 7'b0000110) ||
                  (i_seg == 7'b1111001) || (i_seg == 7'b1111111);
    end
    assign o_seg_ready  = (r_state == COLLECT) && !i_rst;
    assign o_word_valid = (r_state == FULL);
    assign o_word       = r_word;
    assign o_err        = r_err;
    assign o_count      = r_count;
    assign w_accept     = i_seg_valid && o_seg_ready;
`ifdef SEG_ENC_STRICT_EN
    assign w_store = w_accept && w_known;
`else
    assign w_store = w_accept;
`endif
    always_comb begin
        w_state_nx = r_state;
        w_word_nx  = r_word;
        w_err_nx   = r_err;
        w_count_nx = r_count;
        if (r_state == COLLECT) begin
            if (w_accept) w_err_nx = r_err | ~w_known;
            if (w_store) begin
                // slot order U,V,W lands the first character in the top bits
                w_word_nx  = (r_count == 2'd0) ? {w_code, r_word[3:0]} :
                             (r_count == 2'd1) ? {r_word[5:4], w_code, r_word[1:0]} :
                                                 {r_word[5:2], w_code};
                w_count_nx = r_count + 2'd1;
                if (r_count == 2'd2) w_state_nx = FULL;
            end
        end else if (i_word_ready) begin
            w_state_nx = COLLECT;
            w_count_nx = 2'd0;
            w_err_nx   = 1'b0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= COLLECT;
            r_word  <= 6'b111111;
            r_err   <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_word  <= w_word_nx;
            r_err   <= w_err_nx;
            r_count <= w_count_nx;
        end
    end
endmodule
